// File: rtl/ws2812_rx_decoder.sv
// WS2812 receiver: decodes the first GRB word of each frame by high-pulse width
// and forwards the remaining bits of the frame on dout, like a cascaded pixel.
module ws2812_rx_decoder #(
  parameter int THRESH_CYC   = 30,
  parameter int MIN_HIGH_CYC = 5,
  parameter int MAX_HIGH_CYC = 60,
  parameter int RESET_CYC    = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  output logic [23:0] data,
  output logic        data_valid,
  output logic        frame_end,
  output logic        error,
  output logic        dout
);

  localparam int CNT_TOP = (RESET_CYC > MAX_HIGH_CYC + 1) ? RESET_CYC : MAX_HIGH_CYC + 1;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0] HI_ERR = CW'(MAX_HIGH_CYC + 1);
  localparam logic [CW-1:0] LO_END = CW'(RESET_CYC);
  localparam logic [CW-1:0] THR    = CW'(THRESH_CYC);
  localparam logic [CW-1:0] MINH   = CW'(MIN_HIGH_CYC);
  localparam logic [CW-1:0] HI_SAT = '1;

  typedef enum logic [1:0] {CAPTURE, PASS, ERR_WAIT} state_t;

  state_t        state, state_nxt;
  logic          s1, s, s_d;
  logic          rise, fall;
  logic [CW-1:0] hi_cnt, lo_cnt;
  logic          lo_done, seen;
  logic [23:0]   sr;
  logic [4:0]    bitcnt;
  logic          word_done;
  logic          good_fall, bit_val, hi_to, lo_hit;
  logic          frame_end_nxt, error_nxt, dout_nxt;

  assign rise      = s & ~s_d;
  assign fall      = ~s & s_d;
  assign good_fall = fall && (hi_cnt >= MINH);
  assign bit_val   = hi_cnt >= THR;
  // s_d qualifies the compare so a stale count from the previous pulse is never seen on a rise
  assign hi_to     = s_d && (hi_cnt == HI_ERR);
  assign lo_hit    = (lo_cnt == LO_END) && !lo_done;

  always_ff @(posedge clk) begin
    if (rst) state <= CAPTURE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (lo_hit) begin
      state_nxt = CAPTURE;
    end else if (state == CAPTURE) begin
      if (hi_to)                                 state_nxt = ERR_WAIT;
      else if (good_fall && bitcnt == 5'd23)     state_nxt = PASS;
    end
  end

  always_comb begin
    frame_end_nxt = lo_hit && seen;
    error_nxt     = (state == CAPTURE) && (hi_to || (lo_hit && bitcnt != 5'd0));
    dout_nxt      = (state == PASS) && !lo_hit && s_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0; s <= 1'b0; s_d <= 1'b0;
      hi_cnt <= '0; lo_cnt <= '0; lo_done <= 1'b0; seen <= 1'b0;
      sr <= '0; bitcnt <= '0; word_done <= 1'b0;
      data <= '0; data_valid <= 1'b0; frame_end <= 1'b0; error <= 1'b0; dout <= 1'b0;
    end else begin
      s1  <= din;
      s   <= s1;
      s_d <= s;

      // the rise cycle is itself the first high cycle, so the count at the fall equals the width
      if (rise)                       hi_cnt <= CW'(1);
      else if (s && hi_cnt != HI_SAT) hi_cnt <= hi_cnt + CW'(1);

      if (rise)                        lo_cnt <= '0;
      else if (!s && lo_cnt != LO_END) lo_cnt <= lo_cnt + CW'(1);

      if (rise)                  lo_done <= 1'b0;
      else if (lo_cnt == LO_END) lo_done <= 1'b1;

      if (lo_hit)         seen <= 1'b0;
      else if (good_fall) seen <= 1'b1;

      word_done <= 1'b0;
      if (lo_hit) begin
        sr     <= '0;
        bitcnt <= '0;
      end else if (state == CAPTURE) begin
        if (hi_to) begin
          sr     <= '0;
          bitcnt <= '0;
        end else if (good_fall) begin
          sr <= {sr[22:0], bit_val};
          if (bitcnt == 5'd23) begin
            bitcnt    <= '0;
            word_done <= 1'b1;
          end else begin
            bitcnt <= bitcnt + 5'd1;
          end
        end
      end

      data_valid <= word_done;
      if (word_done) data <= sr;
      frame_end <= frame_end_nxt;
      error     <= error_nxt;
      dout      <= dout_nxt;
    end
  end

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Directed bench for ws2812_rx_decoder: word capture, pass-through, glitches,
// truncation, timeout, width thresholds and mid-word reset.
module tb_ws2812_rx_decoder;

  logic        clk, rst, din;
  logic [23:0] data;
  logic        data_valid, frame_end, error, dout;

  ws2812_rx_decoder dut (
    .clk(clk), .rst(rst), .din(din), .data(data), .data_valid(data_valid),
    .frame_end(frame_end), .error(error), .dout(dout)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int cyc;
  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  // event log, sampled mid-cycle
  int          dv_cnt, fe_cnt, err_cnt, both_cnt, dout_hi, run;
  int          dv_cyc, fe_cyc, err_cyc;
  logic [23:0] dv_data;
  logic        dout_prev;
  int          widths[$];
  int          rises[$];
  initial begin
    dv_cnt = 0; fe_cnt = 0; err_cnt = 0; both_cnt = 0; dout_hi = 0; run = 0;
    dv_cyc = 0; fe_cyc = 0; err_cyc = 0; dv_data = '0; dout_prev = 1'b0;
    forever @(negedge clk) begin
      if (data_valid) begin dv_cnt++; dv_data = data; dv_cyc = cyc; end
      if (frame_end) begin fe_cnt++; fe_cyc = cyc; end
      if (error) begin err_cnt++; err_cyc = cyc; end
      if (error && frame_end) both_cnt++;
      if (dout) begin run++; dout_hi++; end
      else if (run != 0) begin widths.push_back(run); run = 0; end
      if (dout && !dout_prev) rises.push_back(cyc);
      dout_prev = dout;
    end
  end

  int vecs = 0, miscompares = 0;
  int dv0, fe0, err0, both0, hi0, w0, r0;
  int last_low, word_start, t;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic snap();
    dv0 = dv_cnt; fe0 = fe_cnt; err0 = err_cnt; both0 = both_cnt;
    hi0 = dout_hi; w0 = widths.size(); r0 = rises.size();
  endtask

  task automatic chk_idle_outputs(string tag);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_dv"}, data_valid, 0);
    chk({tag, "_fe"}, frame_end, 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_dout"}, dout, 0);
  endtask

  // hold din at v for exactly n sampling edges
  task automatic lvl(logic v, int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(int hi, int lo);
    lvl(1'b1, hi);
    last_low = cyc;
    lvl(1'b0, lo);
  endtask

  task automatic send_bit(logic b);
    if (b) pulse(40, 22);
    else   pulse(20, 42);
  endtask

  task automatic send_word(logic [23:0] w, int nbits = 24, int glitch_every = 0);
    word_start = cyc;
    for (int i = 0; i < nbits; i++) begin
      send_bit(w[23-i]);
      if (glitch_every != 0 && (i % glitch_every) == glitch_every - 1 && i < nbits - 1)
        pulse(3, 20);
    end
  endtask

  logic [23:0] pw;

  initial begin
    rst = 1'b1; din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;

    // single word then frame end
    snap();
    send_word(24'h00FF00);
    t = last_low;
    lvl(1'b0, 2600);
    chk("s1_dv_count", dv_cnt - dv0, 1);
    chk("s1_data", dv_data, 24'h00FF00);
    chk("s1_dv_latency", dv_cyc, t + 4);
    chk("s1_fe_count", fe_cnt - fe0, 1);
    chk("s1_fe_time", fe_cyc, t + 2503);
    chk("s1_err_count", err_cnt - err0, 0);
    chk("s1_dout_quiet", dout_hi - hi0, 0);

    // second word of a frame is passed through
    snap();
    send_word(24'hFF0000);
    chk("s2_first_data", data, 24'hFF0000);
    send_word(24'h00FF00);
    t = word_start;
    lvl(1'b0, 2600);
    chk("s2_data_hold", data, 24'hFF0000);
    chk("s2_dv_count", dv_cnt - dv0, 1);
    chk("s2_fe_count", fe_cnt - fe0, 1);
    chk("s2_dout_pulses", widths.size() - w0, 24);
    chk("s2_dout_first_rise", rises[r0], t + 4);
    pw = 24'h00FF00;
    for (int i = 0; i < 24; i++)
      chk($sformatf("s2_dout_width%0d", i), widths[w0 + i], pw[23-i] ? 40 : 20);
    send_word(24'h123456);
    lvl(1'b0, 2600);
    chk("s2_next_frame_data", data, 24'h123456);
    chk("s2_dv_count2", dv_cnt - dv0, 2);
    chk("s2_err_count", err_cnt - err0, 0);

    // short glitches between bits are ignored
    snap();
    send_word(24'hA5A5A5, 24, 4);
    lvl(1'b0, 2600);
    chk("s3_data", data, 24'hA5A5A5);
    chk("s3_dv_count", dv_cnt - dv0, 1);
    chk("s3_err_count", err_cnt - err0, 0);

    // truncated word
    snap();
    send_word(24'hFFC000, 10);
    t = last_low;
    lvl(1'b0, 2600);
    chk("s4_err_count", err_cnt - err0, 1);
    chk("s4_err_with_fe", both_cnt - both0, 1);
    chk("s4_fe_time", fe_cyc, t + 2503);
    chk("s4_dv_count", dv_cnt - dv0, 0);
    chk("s4_data_kept", data, 24'hA5A5A5);

    // over-long high pulse
    snap();
    send_word(24'hA80000, 5);
    t = cyc;
    lvl(1'b1, 100);
    lvl(1'b0, 2600);
    chk("s5_err_count", err_cnt - err0, 1);
    chk("s5_err_time", err_cyc, t + 64);
    chk("s5_fe_count", fe_cnt - fe0, 1);
    chk("s5_no_trunc_err", both_cnt - both0, 0);
    send_word(24'h0F0F0F);
    lvl(1'b0, 2600);
    chk("s5_data", data, 24'h0F0F0F);
    chk("s5_err_count2", err_cnt - err0, 1);

    // reset mid-word
    snap();
    send_word(24'hC0FFEE, 12);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outputs("s6_in_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lvl(1'b0, 2600);
    chk("s6_idle_fe", fe_cnt - fe0, 0);
    chk("s6_idle_err", err_cnt - err0, 0);
    chk("s6_idle_dv", dv_cnt - dv0, 0);
    send_word(24'hC0FFEE);
    lvl(1'b0, 2600);
    chk("s6_data", data, 24'hC0FFEE);
    chk("s6_dv_count", dv_cnt - dv0, 1);
    chk("s6_fe_count", fe_cnt - fe0, 1);

    // width thresholds: 29->0, 30->1, 4 ignored, 5->0, 60->1
    snap();
    pulse(29, 42);
    pulse(30, 42);
    pulse(4, 20);
    pulse(5, 42);
    pulse(60, 22);
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    lvl(1'b0, 2600);
    chk("s7_data", data, 24'h500000);
    chk("s7_dv_count", dv_cnt - dv0, 1);
    chk("s7_err_count", err_cnt - err0, 0);

    // a pulse of exactly MAX_HIGH_CYC+1 is a timeout
    snap();
    send_bit(1'b1);
    t = cyc;
    pulse(61, 42);
    lvl(1'b0, 2600);
    chk("s8_err_count", err_cnt - err0, 1);
    chk("s8_err_time", err_cyc, t + 64);
    chk("s8_no_trunc_err", both_cnt - both0, 0);
    chk("s8_fe_count", fe_cnt - fe0, 1);
    chk("s8_dv_count", dv_cnt - dv0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
